// File: rtl/core_v_mini_mcu_pkg.sv
// rtl/core_v_mini_mcu_pkg.sv - CPU subsystem sizing constants
// Purpose: default hart count and outstanding-transaction limit for the data mux.
// Ports:   none (package)
package core_v_mini_mcu_pkg;

  parameter int NumHartsDefault       = 2;
  parameter int MaxOutstandingDefault = 4;

endpackage

// File: rtl/obi_pkg.sv
// rtl/obi_pkg.sv - OBI data-port request/response types
// Purpose: shared OBI request and response structs for core and bus ports.
// Ports:   none (package)
package obi_pkg;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } obi_resp_t;

endpackage

// File: rtl/cpu_obi_id_fifo.sv
// rtl/cpu_obi_id_fifo.sv - in-flight hart-ID FIFO
// Purpose: records the issuing hart of each accepted bus request, oldest first.
// Ports:   clk_i, rst_ni (async active-low); push_i/data_i write; pop_i read;
//          data_o head entry; full_o, empty_o, count_o occupancy.
module cpu_obi_id_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 1
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           push_i,
  input  logic [WIDTH-1:0]               data_i,
  input  logic                           pop_i,
  output logic [WIDTH-1:0]               data_o,
  output logic                           full_o,
  output logic                           empty_o,
  output logic [$clog2(DEPTH+1)-1:0]     count_o
);

  localparam int PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CntW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PtrW-1:0]  wr_q, wr_d, rd_q, rd_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             do_push, do_pop;

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o  = (cnt_q == CntW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign data_o  = mem_q[rd_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (do_push) begin
      mem_d[wr_q] = data_i;
      wr_d        = ptr_inc(wr_q);
    end
    if (do_pop) begin
      rd_d = ptr_inc(rd_q);
    end
    if (do_push && !do_pop) begin
      cnt_d = cnt_q + 1'b1;
    end else if (do_pop && !do_push) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/cpu_obi_mux.sv
// rtl/cpu_obi_mux.sv - round-robin OBI data-port mux for NUM_HARTS cores
// Purpose: merges per-hart OBI data ports onto one bus master, routing each
//          in-order response back to the hart that issued it.
// Ports:   clk_i, rst_ni (async active-low); core_req_i/core_resp_o per hart;
//          mem_req_o/mem_resp_i bus side; outstanding_o in-flight count;
//          err_o sticky flag for a response with nothing outstanding.
module cpu_obi_mux #(
  parameter int NUM_HARTS       = core_v_mini_mcu_pkg::NumHartsDefault,
  parameter int MAX_OUTSTANDING = core_v_mini_mcu_pkg::MaxOutstandingDefault
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  obi_pkg::obi_req_t                    core_req_i  [NUM_HARTS],
  output obi_pkg::obi_resp_t                   core_resp_o [NUM_HARTS],
  output obi_pkg::obi_req_t                    mem_req_o,
  input  obi_pkg::obi_resp_t                   mem_resp_i,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_o,
  output logic                                 err_o
);
  import obi_pkg::*;

  localparam int IdW  = (NUM_HARTS > 1) ? $clog2(NUM_HARTS) : 1;
  localparam int CntW = $clog2(MAX_OUTSTANDING + 1);

  logic [IdW-1:0]  rr_q, rr_d, locked_id_q, locked_id_d;
  logic [IdW-1:0]  sel, head_id;
  logic            lock_q, lock_d, err_q, err_d;
  logic            sel_valid, fwd, handshake, pop;
  logic            fifo_full, fifo_empty;
  logic [CntW-1:0] count;
  int              cand;

  // Arbitration: a pending (ungranted) request keeps the port until it is
  // accepted; otherwise pick the first requester at or after the RR pointer.
  always_comb begin
    sel       = '0;
    sel_valid = 1'b0;
    cand      = 0;
    if (lock_q && core_req_i[locked_id_q].req) begin
      sel       = locked_id_q;
      sel_valid = 1'b1;
    end else begin
      for (int k = 0; k < NUM_HARTS; k++) begin
        cand = int'(rr_q) + k;
        if (cand >= NUM_HARTS) begin
          cand = cand - NUM_HARTS;
        end
        if (!sel_valid && core_req_i[cand[IdW-1:0]].req) begin
          sel       = cand[IdW-1:0];
          sel_valid = 1'b1;
        end
      end
    end
  end

  // Full blocks forwarding even when a pop lands in the same cycle, keeping
  // the request path independent of rvalid.
  assign fwd       = rst_ni && sel_valid && !fifo_full;
  assign handshake = fwd && mem_resp_i.gnt;
  assign pop       = rst_ni && mem_resp_i.rvalid && !fifo_empty;

  always_comb begin
    mem_req_o = '0;
    if (rst_ni && sel_valid) begin
      mem_req_o     = core_req_i[sel];
      mem_req_o.req = fwd;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_HARTS; i++) begin
      core_resp_o[i]     = '0;
      core_resp_o[i].gnt = handshake && (sel == IdW'(i));
      if (pop && (head_id == IdW'(i))) begin
        core_resp_o[i].rvalid = 1'b1;
        core_resp_o[i].rdata  = mem_resp_i.rdata;
      end
    end
  end

  always_comb begin
    rr_d        = rr_q;
    lock_d      = 1'b0;
    locked_id_d = locked_id_q;
    err_d       = err_q || (mem_resp_i.rvalid && fifo_empty);
    if (handshake) begin
      rr_d = (sel == IdW'(NUM_HARTS - 1)) ? '0 : sel + 1'b1;
    end else if (fwd) begin
      lock_d      = 1'b1;
      locked_id_d = sel;
    end else if (lock_q && core_req_i[locked_id_q].req && fifo_full) begin
      // Stalled by the outstanding limit: the pending request still owns the port.
      lock_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q        <= '0;
      lock_q      <= 1'b0;
      locked_id_q <= '0;
      err_q       <= 1'b0;
    end else begin
      rr_q        <= rr_d;
      lock_q      <= lock_d;
      locked_id_q <= locked_id_d;
      err_q       <= err_d;
    end
  end

  cpu_obi_id_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (IdW)
  ) u_id_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (handshake),
    .data_i  (sel),
    .pop_i   (pop),
    .data_o  (head_id),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (count)
  );

  assign outstanding_o = count;
  assign err_o         = err_q;

endmodule

// File: tb/tb_cpu_obi_mux.sv
// tb/tb_cpu_obi_mux.sv - self-checking bench for cpu_obi_mux
module tb_cpu_obi_mux;
  import obi_pkg::*;

  localparam int NH   = 2;
  localparam int MAXO = 4;

  typedef struct {
    int          hart;
    logic [31:0] addr;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_v   [NH];
  logic        we_v    [NH];
  logic [31:0] addr_v  [NH];
  logic [31:0] wdata_v [NH];
  logic        gnt_v = 1'b0;
  logic        rvalid_v = 1'b0;
  logic [31:0] rdata_v = '0;

  obi_req_t    core_req  [NH];
  obi_resp_t   core_resp [NH];
  obi_req_t    mem_req;
  obi_resp_t   mem_resp;
  logic [2:0]  outstanding;
  logic        err;

  int   checks = 0;
  int   errors = 0;
  int   m_rr = 0;
  int   m_lock_id = 0;
  bit   m_lock = 0;
  bit   m_err = 0;
  ent_t mq[$];

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < NH; i++) begin
      core_req[i].req   = req_v[i];
      core_req[i].we    = we_v[i];
      core_req[i].be    = 4'hF;
      core_req[i].addr  = addr_v[i];
      core_req[i].wdata = wdata_v[i];
    end
    mem_resp.gnt    = gnt_v;
    mem_resp.rvalid = rvalid_v;
    mem_resp.rdata  = rdata_v;
  end

  cpu_obi_mux #(
    .NUM_HARTS       (NH),
    .MAX_OUTSTANDING (MAXO)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .core_req_i    (core_req),
    .core_resp_o   (core_resp),
    .mem_req_o     (mem_req),
    .mem_resp_i    (mem_resp),
    .outstanding_o (outstanding),
    .err_o         (err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic set_req(input logic r0, input logic r1);
    req_v[0] = r0;
    req_v[1] = r1;
  endtask

  // One clock: compare combinational outputs against the model, then advance
  // the model by the same cycle. Entered and left at posedge+1.
  task automatic step();
    int  sel;
    bit  has, full, exp_req, pop, was_empty;
    int  h;
    #1;
    full = (mq.size() == MAXO);
    has  = 0;
    sel  = 0;
    if (m_lock && req_v[m_lock_id]) begin
      has = 1;
      sel = m_lock_id;
    end else begin
      for (int k = 0; k < NH; k++) begin
        int c;
        c = (m_rr + k) % NH;
        if (!has && req_v[c]) begin
          has = 1;
          sel = c;
        end
      end
    end
    exp_req   = has && !full;
    was_empty = (mq.size() == 0);
    pop       = rvalid_v && !was_empty;
    h         = pop ? mq[0].hart : -1;

    chk("mem_req", 32'(mem_req.req), 32'(exp_req));
    chk("mem_addr", mem_req.addr, has ? addr_v[sel] : 32'h0);
    chk("mem_wdata", mem_req.wdata, has ? wdata_v[sel] : 32'h0);
    chk("mem_we", 32'(mem_req.we), has ? 32'(we_v[sel]) : 32'h0);
    for (int i = 0; i < NH; i++) begin
      chk($sformatf("gnt%0d", i), 32'(core_resp[i].gnt), 32'(exp_req && gnt_v && (i == sel)));
      chk($sformatf("rvalid%0d", i), 32'(core_resp[i].rvalid), 32'(h == i));
      chk($sformatf("rdata%0d", i), core_resp[i].rdata, (h == i) ? rdata_v : 32'h0);
    end
    chk("outstanding", 32'(outstanding), 32'(mq.size()));
    chk("err", 32'(err), 32'(m_err));

    if (pop) void'(mq.pop_front());
    if (rvalid_v && was_empty) m_err = 1;
    if (exp_req && gnt_v) begin
      mq.push_back('{hart: sel, addr: addr_v[sel]});
      m_rr   = (sel + 1) % NH;
      m_lock = 0;
    end else if (exp_req) begin
      m_lock    = 1;
      m_lock_id = sel;
    end else if (!(m_lock && req_v[m_lock_id] && full)) begin
      m_lock = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    set_req(0, 0);
    gnt_v = 0;
    for (int n = 0; n < 8 && mq.size() > 0; n++) begin
      rvalid_v = 1;
      rdata_v  = $urandom;
      step();
    end
    rvalid_v = 0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req"}, 32'(mem_req.req), 32'h0);
    chk({tag, "_addr"}, mem_req.addr, 32'h0);
    for (int i = 0; i < NH; i++) begin
      chk($sformatf("%s_gnt%0d", tag, i), 32'(core_resp[i].gnt), 32'h0);
      chk($sformatf("%s_rvalid%0d", tag, i), 32'(core_resp[i].rvalid), 32'h0);
    end
    chk({tag, "_outstanding"}, 32'(outstanding), 32'h0);
    chk({tag, "_err"}, 32'(err), 32'h0);
  endtask

  initial begin
    for (int i = 0; i < NH; i++) begin
      we_v[i]    = i[0];
      addr_v[i]  = 32'h100 * (i + 1);
      wdata_v[i] = 32'hCAFE_0000 + i;
    end
    // Requests and responses active during reset must not leak through.
    set_req(1, 1);
    gnt_v    = 1;
    rvalid_v = 1;
    rdata_v  = 32'h1234;
    #12;
    chk_all_zero("reset");
    rvalid_v = 0;
    #4;
    rst_n = 1;

    // Both harts streaming, rvalid one cycle after each grant.
    gnt_v = 1;
    for (int n = 0; n < 8; n++) begin
      rvalid_v = (mq.size() > 0);
      rdata_v  = (mq.size() > 0) ? (mq[0].addr ^ 32'h5A5A_0000) : 32'h0;
      step();
    end
    drain();

    // Ungranted request holds the port for three cycles.
    addr_v[0] = 32'h2000;
    addr_v[1] = 32'h1000;
    gnt_v = 0;
    set_req(0, 1);
    step();
    set_req(1, 1);
    step();
    step();
    gnt_v = 1;
    step();
    step();
    drain();

    // Outstanding limit.
    set_req(1, 0);
    gnt_v = 1;
    for (int n = 0; n < 5; n++) step();
    chk("full_count", 32'(outstanding), 32'd4);
    rvalid_v = 1;
    rdata_v  = 32'h77;
    step();
    rvalid_v = 0;
    #1;
    chk("refill_gnt", 32'(core_resp[0].gnt), 32'h1);
    step();
    drain();

    // Interleaved issue order, in-order returns.
    gnt_v = 1;
    set_req(1, 0); step();
    set_req(0, 1); step();
    set_req(0, 1); step();
    set_req(1, 0); step();
    set_req(0, 0);
    gnt_v    = 0;
    rvalid_v = 1;
    rdata_v = 32'hA; step();
    rdata_v = 32'hB; step();
    rdata_v = 32'hC; step();
    rdata_v = 32'hD; step();

    // Response with nothing outstanding.
    rdata_v = 32'hDEAD;
    step();
    rvalid_v = 0;
    step();
    chk("err_sticky", 32'(err), 32'h1);

    // Random traffic.
    for (int n = 0; n < 300; n++) begin
      for (int i = 0; i < NH; i++) begin
        req_v[i]   = $urandom_range(0, 1);
        we_v[i]    = $urandom_range(0, 1);
        addr_v[i]  = $urandom;
        wdata_v[i] = $urandom;
      end
      gnt_v    = ($urandom_range(0, 3) != 0);
      rvalid_v = ($urandom_range(0, 2) == 0);
      rdata_v  = $urandom;
      step();
    end
    drain();

    // Asynchronous reset with three transactions in flight.
    set_req(1, 1);
    gnt_v = 1;
    for (int n = 0; n < 3; n++) step();
    chk("pre_reset_count", 32'(outstanding), 32'd3);
    rst_n = 0;
    #1;
    chk_all_zero("midreset");
    mq.delete();
    m_rr   = 0;
    m_lock = 0;
    m_err  = 0;
    @(posedge clk);
    #1;
    rst_n    = 1;
    rvalid_v = 1;
    rdata_v  = 32'hBEEF;
    #1;
    chk("post_reset_gnt0", 32'(core_resp[0].gnt), 32'h1);
    step();
    rvalid_v = 0;
    set_req(0, 0);
    step();
    chk("post_reset_err", 32'(err), 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
